float_special_round: RTL and testbench
======================================

Name: float_special_round

Overview:
- Registered floating-point post-processing stage that sits between format arithmetic (e.g. a precision converter) and the result bus.
- Classifies an operand as zero, infinity, signaling NaN or quiet NaN.
- Independently rounds an unrounded exponent/mantissa pair to the output format using round-to-nearest-even or truncation, and flags exponent overflow.
- Both results are registered with one cycle of latency.

Parameters:
- EXPONENT_WIDTH, 8: exponent field width E (>=2).
- MANTISSA_WIDTH, 23: stored fraction width M (>=2).
- ROUND_TO_NEAREST, 1: 1 = round to nearest, ties to even; 0 = truncate.
- ROUNDING_BITS, 3: width R of the discarded-bits input (>=1, also required when truncating).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  inputs are valid this cycle.
- operand  in  E+M+1  packed {sign, exponent, fraction} value to classify.
- non_rounded_exponent  in  E+1  biased exponent; the MSB is a headroom/overflow bit.
- non_rounded_mantissa  in  M+1  {carry bit, fraction[M-1:0]}.
- rounding_bits  in  R  bits discarded below the fraction LSB, MSB first (guard, then sticky bits).
- out_valid  out  1  outputs hold the results of the previous valid input.
- is_infinite  out  1  operand is ±infinity.
- is_zero  out  1  operand is ±0.
- is_signaling_nan  out  1  operand is a signaling NaN.
- is_quiet_nan  out  1  operand is a quiet NaN.
- rounded_exponent  out  E  rounded exponent.
- rounded_mantissa  out  M  rounded fraction.
- overflow_flag  out  1  rounding result exceeded the largest finite exponent.

Behaviour:
- Reset: while rst=1 at a clock edge, every output register including out_valid is cleared to 0. rst takes priority over in_valid.
- Latency: 1 cycle.
  - out_valid is in_valid registered.
  - Data registers load only when in_valid=1 and otherwise hold their value.
- Classification (combinational, then registered). Let exp = operand[E+M-1:M] and frac = operand[M-1:0].
  - is_zero: exp==0 and frac==0. Both signs qualify.
  - is_infinite: exp is all ones and frac==0.
  - is_quiet_nan: exp is all ones, frac!=0 and frac[M-1]=1.
  - is_signaling_nan: exp is all ones, frac!=0 and frac[M-1]=0.
  - Subnormals and normals assert no flag. The four flags are mutually exclusive.
- Rounding, ROUND_TO_NEAREST=1:
  - guard = rounding_bits[R-1].
  - sticky = OR of rounding_bits[R-2:0], or 0 when R=1.
  - lsb = non_rounded_mantissa[0].
  - inc = guard & (sticky | lsb).
- Rounding, ROUND_TO_NEAREST=0: inc = 0 and rounding_bits is ignored.
- Mantissa sum: sum = non_rounded_mantissa + inc, computed M+2 bits wide.
  - carry = sum[M] or sum[M+1].
  - exp_r = non_rounded_exponent + carry, computed E+2 bits wide.
  - The output fraction is sum[M-1:0]. A rounding carry out of an all-ones fraction yields fraction 0.
- Overflow: when exp_r >= 2^E - 1:
  - rounded_exponent = all ones, rounded_mantissa = 0, overflow_flag = 1.
  - This case includes any input with non_rounded_exponent[E]=1.
- Otherwise: rounded_exponent = exp_r[E-1:0], overflow_flag = 0.
- There is no underflow detection; exponent 0 passes through unchanged.
- Classification and rounding paths are independent and produce results in the same cycle.

Decomposition:
- Shared package fp_pkg holds:
  - a function returning the all-ones exponent constant for a given width;
  - a struct/enum for the four special-class flags.
- Sub-module special_float_classifier (purely combinational, parameters E and M) implements classification. The rounding logic and output registers stay in float_special_round.

Test Plan (all with E=8, M=23, R=3 unless stated):
- Classification, one value per cycle:
  - 0x7F800000 -> is_infinite=1.
  - 0x80000000 -> is_zero=1.
  - 0x7FC00000 -> is_quiet_nan=1.
  - 0x7F800001 -> is_signaling_nan=1.
  - 0x00000001 -> all flags 0.
  - Each result appears exactly one cycle later with out_valid=1.
- Ties to even, exponent 0x080:
  - mantissa 0x000001, rounding_bits=100 -> 0x000002.
  - mantissa 0x000002, rounding_bits=100 -> 0x000002.
  - mantissa 0x000002, rounding_bits=101 -> 0x000003.
  - mantissa 0x000002, rounding_bits=011 -> 0x000002.
  - Exponent stays 0x80 in all four cases.
- Carry propagation: exponent 0x07F, mantissa 0x7FFFFF, rounding_bits=110 -> exponent 0x80, mantissa 0x000000, overflow_flag=0.
- Overflow:
  - exponent 0x0FE, mantissa 0x7FFFFF, rounding_bits=100 -> exponent 0xFF, mantissa 0, overflow_flag=1.
  - exponent 0x100, mantissa 0x000000 -> overflow_flag=1.
  - exponent 0x0FF -> overflow_flag=1.
- Truncation, ROUND_TO_NEAREST=0: mantissa 0x123456, rounding_bits=111 -> 0x123456 unchanged. Separately, R=1 with ROUND_TO_NEAREST=1: mantissa 0x000001, rounding_bits=1 -> 0x000002.
- Reset and hold:
  - Assert rst together with in_valid=1 -> all outputs 0 next cycle.
  - Deassert rst and drop in_valid after one valid input -> out_valid pulses for one cycle and the data outputs hold.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: special-value class flags and the
// all-ones exponent constant used by classification and overflow saturation.
package fp_pkg;

  typedef struct packed {
    logic is_infinite;
    logic is_zero;
    logic is_signaling_nan;
    logic is_quiet_nan;
  } special_class_t;

  // Valid for widths up to 31, which covers every practical exponent field.
  function automatic int unsigned all_ones_exp(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/float_special_round_if.sv
// Bundle of the classify/round request and registered result signals.
// The master side drives the request; the slave side (the stage) returns results.
interface float_special_round_if #(
  parameter int E = 8,
  parameter int M = 23,
  parameter int R = 3
);
  logic           in_valid;
  logic [E+M:0]   operand;
  logic [E:0]     non_rounded_exponent;
  logic [M:0]     non_rounded_mantissa;
  logic [R-1:0]   rounding_bits;

  logic           out_valid;
  logic           is_infinite;
  logic           is_zero;
  logic           is_signaling_nan;
  logic           is_quiet_nan;
  logic [E-1:0]   rounded_exponent;
  logic [M-1:0]   rounded_mantissa;
  logic           overflow_flag;

  modport master (
    output in_valid, operand, non_rounded_exponent, non_rounded_mantissa, rounding_bits,
    input  out_valid, is_infinite, is_zero, is_signaling_nan, is_quiet_nan,
           rounded_exponent, rounded_mantissa, overflow_flag
  );

  modport slave (
    input  in_valid, operand, non_rounded_exponent, non_rounded_mantissa, rounding_bits,
    output out_valid, is_infinite, is_zero, is_signaling_nan, is_quiet_nan,
           rounded_exponent, rounded_mantissa, overflow_flag
  );
endinterface

// File: rtl/special_float_classifier.sv
// Combinational classifier: flags +/-0, +/-inf, signaling NaN and quiet NaN.
// Normals and subnormals raise no flag; the four flags are mutually exclusive.
module special_float_classifier
  import fp_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic [E+M:0]    operand_i,
  output special_class_t  class_o
);
  localparam logic [E-1:0] EXP_ONES = E'(all_ones_exp(E));

  logic [E-1:0] exp_field;
  logic [M-1:0] frac_field;
  logic         exp_zero;
  logic         exp_max;
  logic         frac_zero;
  logic         unused_sign;

  assign exp_field   = operand_i[E+M-1:M];
  assign frac_field  = operand_i[M-1:0];
  assign unused_sign = operand_i[E+M];

  assign exp_zero  = (exp_field == '0);
  assign exp_max   = (exp_field == EXP_ONES);
  assign frac_zero = (frac_field == '0);

  // The fraction MSB is the quiet bit that separates qNaN from sNaN.
  assign class_o.is_zero          = exp_zero & frac_zero;
  assign class_o.is_infinite      = exp_max & frac_zero;
  assign class_o.is_quiet_nan     = exp_max & ~frac_zero & frac_field[M-1];
  assign class_o.is_signaling_nan = exp_max & ~frac_zero & ~frac_field[M-1];
endmodule

// File: rtl/float_special_round.sv
// Registered post-processing stage: classifies an operand and, independently,
// rounds an exponent/mantissa pair with overflow saturation. One cycle latency.
module float_special_round
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  float_special_round_if.slave  bus
);
  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int R = ROUNDING_BITS;
  localparam logic [E-1:0] EXP_ONES  = E'(all_ones_exp(E));
  localparam logic [E+1:0] OVF_LIMIT = {2'b00, EXP_ONES};

  special_class_t class_d;
  logic           inc;
  logic [M+1:0]   sum;
  logic           carry;
  logic [E+1:0]   exp_r;
  logic           overflow_d;
  logic [E-1:0]   rexp_d;
  logic [M-1:0]   rman_d;

  logic           out_valid_q;
  special_class_t class_q;
  logic [E-1:0]   rexp_q;
  logic [M-1:0]   rman_q;
  logic           overflow_q;

  special_float_classifier #(
    .E (E),
    .M (M)
  ) u_classifier (
    .operand_i (bus.operand),
    .class_o   (class_d)
  );

  generate
    if (ROUND_TO_NEAREST != 0) begin : g_rne
      logic guard;
      logic sticky;
      assign guard = bus.rounding_bits[R-1];
      if (R > 1) begin : g_sticky
        assign sticky = |bus.rounding_bits[R-2:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end
      // Round up above the halfway point, or at a tie when the LSB is odd.
      assign inc = guard & (sticky | bus.non_rounded_mantissa[0]);
    end else begin : g_trunc
      logic unused_rounding;
      assign unused_rounding = ^bus.rounding_bits;
      assign inc = 1'b0;
    end
  endgenerate

  assign sum   = {1'b0, bus.non_rounded_mantissa} + {{(M+1){1'b0}}, inc};
  assign carry = sum[M] | sum[M+1];
  assign exp_r = {1'b0, bus.non_rounded_exponent} + {{(E+1){1'b0}}, carry};

  // Anything reaching the reserved exponent saturates to infinity.
  assign overflow_d = (exp_r >= OVF_LIMIT);
  assign rexp_d     = overflow_d ? EXP_ONES : exp_r[E-1:0];
  assign rman_d     = overflow_d ? '0 : sum[M-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      class_q     <= '0;
      rexp_q      <= '0;
      rman_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        class_q    <= class_d;
        rexp_q     <= rexp_d;
        rman_q     <= rman_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.is_infinite      = class_q.is_infinite;
  assign bus.is_zero          = class_q.is_zero;
  assign bus.is_signaling_nan = class_q.is_signaling_nan;
  assign bus.is_quiet_nan     = class_q.is_quiet_nan;
  assign bus.rounded_exponent = rexp_q;
  assign bus.rounded_mantissa = rman_q;
  assign bus.overflow_flag    = overflow_q;
endmodule

// File: tb/tb_float_special_round.sv
// Bench for float_special_round: three configurations (RNE R=3, truncate R=3,
// RNE R=1) driven together, checked against an arithmetic reference model.
module tb_float_special_round;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_special_round_if #(.E(8), .M(23), .R(3)) bus_a ();
  float_special_round_if #(.E(8), .M(23), .R(3)) bus_t ();
  float_special_round_if #(.E(8), .M(23), .R(1)) bus_s ();

  float_special_round #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(3))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  float_special_round #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(0), .ROUNDING_BITS(3))
    dut_t (.clk(clk), .rst(rst), .bus(bus_t));
  float_special_round #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1), .ROUNDING_BITS(1))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  typedef struct {
    bit       v;
    bit [3:0] cls;   // {inf, zero, snan, qnan}
    int       e;
    int       m;
    bit       ovf;
  } exp_t;

  exp_t ea, et, es;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: classify from the IEEE field definitions.
  function automatic bit [3:0] classify(input logic [31:0] op);
    int ex = int'(op[30:23]);
    int fr = int'(op[22:0]);
    if (ex == 0 && fr == 0)   return 4'b0100;
    if (ex == 255 && fr == 0) return 4'b1000;
    if (ex == 255)            return (fr >= 32'h400000) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  // Reference: treat mantissa.rounding_bits as a fixed-point number and round it.
  task automatic round_model(input int e_in, input int m_in, input int rb, input int r, input bit rne,
                             output int e_out, output int m_out, output bit ovf);
    longint scaled = (longint'(m_in) << r) + longint'(rb);
    longint q      = scaled >> r;
    longint rem    = scaled - (q << r);
    longint half   = longint'(1) << (r - 1);
    if (rne && (rem > half || (rem == half && (q % 2) == 1))) q++;
    e_out = e_in + ((q >= (longint'(1) << 23)) ? 1 : 0);
    m_out = int'(q % (longint'(1) << 23));
    ovf   = 1'b0;
    if (e_out >= 255) begin
      e_out = 255;
      m_out = 0;
      ovf   = 1'b1;
    end
  endtask

  task automatic update(inout exp_t x, input bit v, input logic [31:0] op, input int e, input int m,
                        input int rb, input int r, input bit rne);
    if (rst) begin
      x.v = 0; x.cls = 0; x.e = 0; x.m = 0; x.ovf = 0;
    end else begin
      x.v = v;
      if (v) begin
        x.cls = classify(op);
        round_model(e, m, rb, r, rne, x.e, x.m, x.ovf);
      end
    end
  endtask

  task automatic check_one(input string n, input exp_t x, input logic ov, input logic [3:0] cls,
                           input logic [7:0] e, input logic [22:0] m, input logic ovf);
    check({n, "_valid"}, 64'(ov), 64'(x.v));
    check({n, "_class"}, 64'(cls), 64'(x.cls));
    check({n, "_exp"},   64'(e),   64'(x.e));
    check({n, "_man"},   64'(m),   64'(x.m));
    check({n, "_ovf"},   64'(ovf), 64'(x.ovf));
  endtask

  task automatic step(input bit v, input logic [31:0] op, input int e, input int m, input int rb3, input int rb1);
    bus_a.in_valid = v; bus_a.operand = op; bus_a.non_rounded_exponent = 9'(e);
    bus_a.non_rounded_mantissa = 24'(m); bus_a.rounding_bits = 3'(rb3);
    bus_t.in_valid = v; bus_t.operand = op; bus_t.non_rounded_exponent = 9'(e);
    bus_t.non_rounded_mantissa = 24'(m); bus_t.rounding_bits = 3'(rb3);
    bus_s.in_valid = v; bus_s.operand = op; bus_s.non_rounded_exponent = 9'(e);
    bus_s.non_rounded_mantissa = 24'(m); bus_s.rounding_bits = 1'(rb1);
    update(ea, v, op, e, m, rb3, 3, 1'b1);
    update(et, v, op, e, m, rb3, 3, 1'b0);
    update(es, v, op, e, m, rb1, 1, 1'b1);
    @(posedge clk);
    #1;
    $display("txn v=%0b op=%08h e=%03h m=%06h rb=%0d -> a: v=%0b e=%02h m=%06h ovf=%0b",
             v, op, e, m, rb3, bus_a.out_valid, bus_a.rounded_exponent, bus_a.rounded_mantissa,
             bus_a.overflow_flag);
    check_one("a", ea, bus_a.out_valid,
              {bus_a.is_infinite, bus_a.is_zero, bus_a.is_signaling_nan, bus_a.is_quiet_nan},
              bus_a.rounded_exponent, bus_a.rounded_mantissa, bus_a.overflow_flag);
    check_one("t", et, bus_t.out_valid,
              {bus_t.is_infinite, bus_t.is_zero, bus_t.is_signaling_nan, bus_t.is_quiet_nan},
              bus_t.rounded_exponent, bus_t.rounded_mantissa, bus_t.overflow_flag);
    check_one("s", es, bus_s.out_valid,
              {bus_s.is_infinite, bus_s.is_zero, bus_s.is_signaling_nan, bus_s.is_quiet_nan},
              bus_s.rounded_exponent, bus_s.rounded_mantissa, bus_s.overflow_flag);
  endtask

  typedef struct { logic [31:0] op; logic [3:0] cls; } cls_vec_t;
  typedef struct { int e; int m; int rb; int we; int wm; bit wo; } rnd_vec_t;

  cls_vec_t cls_tab[5] = '{
    '{32'h7F800000, 4'b1000}, '{32'h80000000, 4'b0100}, '{32'h7FC00000, 4'b0001},
    '{32'h7F800001, 4'b0010}, '{32'h00000001, 4'b0000}};

  rnd_vec_t rnd_tab[8] = '{
    '{'h080, 'h000001, 3'b100, 'h80, 'h000002, 0},
    '{'h080, 'h000002, 3'b100, 'h80, 'h000002, 0},
    '{'h080, 'h000002, 3'b101, 'h80, 'h000003, 0},
    '{'h080, 'h000002, 3'b011, 'h80, 'h000002, 0},
    '{'h07F, 'h7FFFFF, 3'b110, 'h80, 'h000000, 0},
    '{'h0FE, 'h7FFFFF, 3'b100, 'hFF, 'h000000, 1},
    '{'h100, 'h000000, 3'b000, 'hFF, 'h000000, 1},
    '{'h0FF, 'h000000, 3'b000, 'hFF, 'h000000, 1}};

  initial begin
    logic [31:0] op;
    logic [22:0] held_m;

    // Reset wins over in_valid.
    rst = 1'b1;
    step(1'b1, 32'h7F800000, 'h0FE, 'h7FFFFF, 3'b100, 1);
    check("rst_all", 64'({bus_a.out_valid, bus_a.is_infinite, bus_a.rounded_exponent,
                          bus_a.rounded_mantissa, bus_a.overflow_flag}), 64'd0);
    rst = 1'b0;

    foreach (cls_tab[i]) begin
      step(1'b1, cls_tab[i].op, 'h080, 0, 0, 0);
      check($sformatf("cls%0d", i),
            64'({bus_a.out_valid, bus_a.is_infinite, bus_a.is_zero, bus_a.is_signaling_nan, bus_a.is_quiet_nan}),
            64'({1'b1, cls_tab[i].cls}));
    end

    foreach (rnd_tab[i]) begin
      step(1'b1, 32'h3F800000, rnd_tab[i].e, rnd_tab[i].m, rnd_tab[i].rb, 0);
      check($sformatf("rnd%0d_exp", i), 64'(bus_a.rounded_exponent), 64'(rnd_tab[i].we));
      check($sformatf("rnd%0d_man", i), 64'(bus_a.rounded_mantissa), 64'(rnd_tab[i].wm));
      check($sformatf("rnd%0d_ovf", i), 64'(bus_a.overflow_flag), 64'(rnd_tab[i].wo));
    end

    step(1'b1, 32'h3F800000, 'h080, 'h123456, 3'b111, 1);
    check("trunc_man", 64'(bus_t.rounded_mantissa), 64'h123456);
    step(1'b1, 32'h3F800000, 'h080, 'h000001, 3'b111, 1);
    check("r1_man", 64'(bus_s.rounded_mantissa), 64'h000002);

    // One valid input followed by idle: valid pulses once, data holds.
    held_m = bus_a.rounded_mantissa;
    step(1'b0, 32'h7FC00000, 'h0FF, 'h7FFFFF, 3'b111, 1);
    check("hold_valid", 64'(bus_a.out_valid), 64'd0);
    check("hold_man", 64'(bus_a.rounded_mantissa), 64'(held_m));
    step(1'b0, 32'h00000000, 'h001, 'h000000, 3'b000, 0);
    check("hold_man2", 64'(bus_a.rounded_mantissa), 64'(held_m));

    for (int n = 0; n < 300; n++) begin
      op = $urandom;
      case ($urandom_range(0, 3))
        0: op[30:23] = 8'hFF;
        1: op[30:23] = 8'h00;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) op[22:0] = '0;
      step($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 511)),
           int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
